// File: rtl/mouse_tracker.sv
// PS/2 mouse stream receiver: deframes 11-bit frames, assembles 3-byte packets and
// integrates the X delta into a clamped absolute position plus the left button state.
module mouse_tracker #(
  parameter logic [15:0] X_MAX          = 16'd639,
  parameter int          TIMEOUT_CYCLES = 5000
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] mouse_x,
  output logic        mouse_pressed_,
  output logic        packet_valid,
  output logic        frame_error
);

  localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2, S_STOP = 2'd3;
  localparam logic [1:0] S_BYTE0 = 2'd0, S_BYTE1 = 2'd1, S_BYTE2 = 2'd2;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic [1:0]    ck_sync_q, ck_sync_d, dt_sync_q, dt_sync_d;
  logic          ck_prev_q, ck_prev_d;
  logic [1:0]    bit_st_q, bit_st_d, byte_st_q, byte_st_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d, dx_lo_q, dx_lo_d;
  logic          par_ok_q, par_ok_d;
  logic          btn_q, btn_d, xs_q, xs_d, xo_q, xo_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   mouse_x_q, mouse_x_d;
  logic          pressed_q, pressed_d, valid_q, valid_d, ferr_q, ferr_d;

  logic              sdata, fall, active, timeout_hit, byte_done, bit_err;
  logic signed [16:0] sum_s;

  assign sdata       = dt_sync_q[1];
  assign active      = (bit_st_q != S_IDLE) || (byte_st_q != S_BYTE0);
  assign timeout_hit = active && (timer_q == TMAX);
  // A falling edge in the timeout cycle is deliberately ignored.
  assign fall        = ck_prev_q & ~ck_sync_q[1] & ~timeout_hit;
  assign sum_s       = $signed({1'b0, mouse_x_q}) + $signed({{8{xs_q}}, xs_q, dx_lo_q});

  always_comb begin
    ck_sync_d = {ck_sync_q[0], ps2_clk};
    dt_sync_d = {dt_sync_q[0], ps2_data};
    ck_prev_d = ck_sync_q[1];
    bit_st_d  = bit_st_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    byte_done = 1'b0;
    bit_err   = 1'b0;
    case (bit_st_q)
      S_IDLE: begin
        if (fall && !sdata) begin
          bit_st_d  = S_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          bit_st_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d   = {sdata, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          bit_st_d  = (bit_cnt_q == 3'd7) ? S_PARITY : S_DATA;
        end else begin
          bit_st_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_ok_d = odd_parity_ok(shift_q, sdata);
          bit_st_d = S_STOP;
        end else begin
          bit_st_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (fall) begin
          byte_done = sdata & par_ok_q;
          bit_err   = ~(sdata & par_ok_q);
          bit_st_d  = S_IDLE;
        end else begin
          bit_st_d = S_STOP;
        end
      end
      default: bit_st_d = S_IDLE;
    endcase

    byte_st_d = byte_st_q;
    btn_d     = btn_q;
    xs_d      = xs_q;
    xo_d      = xo_q;
    dx_lo_d   = dx_lo_q;
    mouse_x_d = mouse_x_q;
    pressed_d = pressed_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    if (byte_done) begin
      case (byte_st_q)
        S_BYTE0: begin
          // Bytes without the always-one bit 3 are dropped to regain packet alignment.
          if (shift_q[3]) begin
            btn_d     = shift_q[0];
            xs_d      = shift_q[4];
            xo_d      = shift_q[6];
            byte_st_d = S_BYTE1;
          end else begin
            byte_st_d = S_BYTE0;
          end
        end
        S_BYTE1: begin
          dx_lo_d   = shift_q;
          byte_st_d = S_BYTE2;
        end
        S_BYTE2: begin
          if (xo_q) mouse_x_d = mouse_x_q;
          else if (sum_s[16]) mouse_x_d = 16'd0;
          else if (sum_s[15:0] > X_MAX) mouse_x_d = X_MAX;
          else mouse_x_d = sum_s[15:0];
          pressed_d = ~btn_q;
          valid_d   = 1'b1;
          byte_st_d = S_BYTE0;
        end
        default: byte_st_d = S_BYTE0;
      endcase
    end else begin
      byte_st_d = byte_st_q;
    end

    if (bit_err || timeout_hit) begin
      ferr_d    = 1'b1;
      bit_st_d  = S_IDLE;
      byte_st_d = S_BYTE0;
    end else begin
      ferr_d = 1'b0;
    end

    if (timeout_hit || !active || fall) timer_d = '0;
    else timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      ck_sync_q <= 2'b11;
      dt_sync_q <= 2'b11;
      ck_prev_q <= 1'b1;
      bit_st_q  <= S_IDLE;
      byte_st_q <= S_BYTE0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      par_ok_q  <= 1'b0;
      btn_q     <= 1'b0;
      xs_q      <= 1'b0;
      xo_q      <= 1'b0;
      dx_lo_q   <= 8'd0;
      timer_q   <= '0;
      mouse_x_q <= 16'd0;
      pressed_q <= 1'b1;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      ck_sync_q <= ck_sync_d;
      dt_sync_q <= dt_sync_d;
      ck_prev_q <= ck_prev_d;
      bit_st_q  <= bit_st_d;
      byte_st_q <= byte_st_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      btn_q     <= btn_d;
      xs_q      <= xs_d;
      xo_q      <= xo_d;
      dx_lo_q   <= dx_lo_d;
      timer_q   <= timer_d;
      mouse_x_q <= mouse_x_d;
      pressed_q <= pressed_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign mouse_x        = mouse_x_q;
  assign mouse_pressed_ = pressed_q;
  assign packet_valid   = valid_q;
  assign frame_error    = ferr_q;

endmodule
